// File: rtl/alu_result_serializer.sv
// alu_result_serializer
//   Buffers up to four 49-bit ALU results ({error, result[47:0]}) in a
//   circular FIFO. Each result is streamed out as three 16-bit words,
//   low word first, over a valid/ready handshake.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   valid, error,       ALU result input, one result per cycle with valid=1
//   result[47:0]
//   out_data[15:0]      current output word (zero when buffer empty)
//   out_valid           out_data holds a valid word
//   out_ready           consumer accepts word when out_valid && out_ready
//   out_last            current word is the third word of a result
//   out_err             error flag of the result being streamed
//   full                buffer holds 4 results
//   drop                one-cycle pulse, an incoming result was lost
//   err_count[7:0]      (ALU_RES_ERR_CNT_EN only) saturating count of
//                       captured results with error=1
//
// Build option
//   ALU_RES_ERR_CNT_EN  adds the err_count output and its counter.
module alu_result_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic        error,
    input  logic [47:0] result,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        out_err,
    output logic        full,
    output logic        drop
`ifdef ALU_RES_ERR_CNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    logic [48:0] mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q, count_d;
    logic [1:0]  beat_q, beat_d;
    logic        drop_q;

    logic        push, accept, pop;
    logic [48:0] head;

    // A pop in the same cycle never frees a slot for a write at count==4:
    // the push decision looks only at the registered count.
    assign push   = valid && (count_q != 3'd4);
    assign accept = out_valid && out_ready;
    assign pop    = accept && (beat_q == 2'd2);
    assign head   = mem_q[rd_ptr_q];

    assign full      = (count_q == 3'd4);
    assign out_valid = (count_q != 3'd0);
    assign drop      = drop_q;

    always_comb begin
        out_data = 16'h0000;
        out_err  = 1'b0;
        out_last = 1'b0;
        if (out_valid) begin
            out_err  = head[48];
            out_last = (beat_q == 2'd2);
            case (beat_q)
                2'd0:    out_data = head[15:0];
                2'd1:    out_data = head[31:16];
                2'd2:    out_data = head[47:32];
                default: out_data = 16'h0000;
            endcase
        end
    end

    always_comb begin
        count_d = count_q + {2'b00, push} - {2'b00, pop};
        beat_d  = beat_q;
        if (accept) beat_d = (beat_q == 2'd2) ? 2'd0 : beat_q + 2'd1;
    end

    // Storage needs no reset: it is only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {error, result};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            beat_q   <= 2'd0;
            drop_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_d;
            beat_q  <= beat_d;
            drop_q  <= valid && (count_q == 3'd4);
        end
    end

`ifdef ALU_RES_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    err_cnt_q <= 8'd0;
        else if (push && error && err_cnt_q != 8'hFF)  err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed self-checking bench for alu_result_serializer.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so every check sees the state produced by the preceding edge.
module tb_alu_result_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, error, out_ready;
    logic [47:0] result;
    logic [15:0] out_data;
    logic        out_valid, out_last, out_err, full, drop;
`ifdef ALU_RES_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .error     (error),
        .result    (result),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_err   (out_err),
        .full      (full),
        .drop      (drop)
`ifdef ALU_RES_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks one output word in full.
    task automatic check_word(input string tag, input logic [15:0] d, input logic l, input logic e);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".data"},  64'(out_data),  64'(d));
        check({tag, ".last"},  64'(out_last),  64'(l));
        check({tag, ".err"},   64'(out_err),   64'(e));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'd0);
        check({tag, ".data"},  64'(out_data),  64'd0);
        check({tag, ".last"},  64'(out_last),  64'd0);
        check({tag, ".err"},   64'(out_err),   64'd0);
        check({tag, ".full"},  64'(full),      64'd0);
        check({tag, ".drop"},  64'(drop),      64'd0);
    endtask

    logic [47:0] burst [5];
    logic        burst_err [5];

    initial begin
        burst[0] = 48'h0103_0102_0101; burst_err[0] = 1'b0;
        burst[1] = 48'h0203_0202_0201; burst_err[1] = 1'b1;
        burst[2] = 48'h0303_0302_0301; burst_err[2] = 1'b0;
        burst[3] = 48'h0403_0402_0401; burst_err[3] = 1'b0;
        burst[4] = 48'h0503_0502_0501; burst_err[4] = 1'b1;

        rst_n = 1'b0; valid = 1'b0; error = 1'b0; result = 48'h0; out_ready = 1'b0;
        step(); step();
        check_idle("reset");
`ifdef ALU_RES_ERR_CNT_EN
        check("reset.err_count", 64'(err_count), 64'd0);
`endif
        rst_n = 1'b1;

        // Single result streamed with out_ready held high.
        out_ready = 1'b1;
        valid = 1'b1; error = 1'b0; result = 48'h3333_2222_1111;
        step();
        valid = 1'b0;
        check_word("single.w0", 16'h1111, 1'b0, 1'b0);
        step();
        check_word("single.w1", 16'h2222, 1'b0, 1'b0);
        step();
        check_word("single.w2", 16'h3333, 1'b1, 1'b0);
        step();
        check_idle("single.empty");

        // Fill with out_ready low, fifth result is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; error = burst_err[i]; result = burst[i];
            step();
            if (i == 2) check("fill.full_after3", 64'(full), 64'd0);
            if (i == 3) begin
                check("fill.full_after4", 64'(full), 64'd1);
                check("fill.nodrop_after4", 64'(drop), 64'd0);
            end
        end
        valid = 1'b0; error = 1'b0;
        check("fill.drop", 64'(drop), 64'd1);
        check("fill.full_held", 64'(full), 64'd1);
        step();
        check("fill.drop_pulse", 64'(drop), 64'd0);
        check("fill.full_still", 64'(full), 64'd1);
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 3; b++) begin
                logic [47:0] w;
                w = burst[r];
                check_word($sformatf("drain.r%0d.b%0d", r, b), w[16*b +: 16], b == 2, burst_err[r]);
                step();
            end
        end
        check_idle("drain.empty");

        // Stalled stream: each word must hold while out_ready is low.
        valid = 1'b1; error = 1'b0; result = 48'hAAAA_BBBB_CCCC;
        step();
        valid = 1'b0; out_ready = 1'b0;
        check_word("stall.w0", 16'hCCCC, 1'b0, 1'b0);
        step();
        check_word("stall.w0_hold", 16'hCCCC, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_word("stall.w1", 16'hBBBB, 1'b0, 1'b0);
        step();
        check_word("stall.w1_hold", 16'hBBBB, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_word("stall.w2", 16'hAAAA, 1'b1, 1'b0);
        step();
        check_word("stall.w2_hold", 16'hAAAA, 1'b1, 1'b0);
        out_ready = 1'b1;
        step();
        check_idle("stall.empty");

        // One result every third cycle: simultaneous push/pop, pointer wrap.
        valid = 1'b1; error = 1'b0; result = {16'h0002, 16'h0001, 16'h0000};
        step();
        for (int i = 0; i < 10; i++) begin
            for (int b = 0; b < 3; b++) begin
                check_word($sformatf("rate.r%0d.b%0d", i, b), 16'(16 * i + b), b == 2, 1'b0);
                check($sformatf("rate.r%0d.b%0d.full", i, b), 64'(full), 64'd0);
                check($sformatf("rate.r%0d.b%0d.drop", i, b), 64'(drop), 64'd0);
                valid  = (b == 2) && (i < 9);
                result = {16'(16 * (i + 1) + 2), 16'(16 * (i + 1) + 1), 16'(16 * (i + 1))};
                step();
            end
        end
        valid = 1'b0;
        check_idle("rate.empty");

        // Reset during beat1 of an error result.
        valid = 1'b1; error = 1'b1; result = 48'h0009_0008_0007;
        step();
        valid = 1'b0; error = 1'b0;
        check_word("rst.w0", 16'h0007, 1'b0, 1'b1);
        step();
        check_word("rst.w1", 16'h0008, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_idle("rst.async");
`ifdef ALU_RES_ERR_CNT_EN
        check("rst.err_count", 64'(err_count), 64'd0);
`endif
        step();
        rst_n = 1'b1;
        step();
        check_idle("rst.after");
        valid = 1'b1; error = 1'b0; result = 48'h0006_0005_0004;
        step();
        valid = 1'b0;
        check_word("rst.next.w0", 16'h0004, 1'b0, 1'b0);
        step();
        check_word("rst.next.w1", 16'h0005, 1'b0, 1'b0);
        step();
        check_word("rst.next.w2", 16'h0006, 1'b1, 1'b0);
        step();
        check_idle("rst.next.empty");

`ifdef ALU_RES_ERR_CNT_EN
        // 300 captured error results saturate the counter at 8'hFF.
        for (int i = 0; i < 300; i++) begin
            valid = 1'b1; error = 1'b1; result = 48'h000C_000B_000A;
            step();
            valid = 1'b0; error = 1'b0;
            for (int b = 0; b < 3; b++) begin
                check($sformatf("sat.r%0d.b%0d.err", i, b), 64'(out_err), 64'd1);
                if (b < 2) step();
            end
            check($sformatf("sat.r%0d.cnt", i), 64'(err_count), (i < 255) ? 64'(i + 1) : 64'hFF);
            step();
        end
        check("sat.final", 64'(err_count), 64'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
